// File: rtl/cell_frame_sequencer.sv
// Walks every cell of a WIDTH x HEIGHT grid once per accepted frame_start,
// fetching each cell's color from a source and writing it to a matrix display.
module cell_frame_sequencer #(
    parameter int WIDTH    = 20,
    parameter int HEIGHT   = 15,
    parameter int B_WIDTH  = 5,
    parameter int B_HEIGHT = 4,
    parameter int B_VGA    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start,
    output logic                  px_req,
    output logic [B_WIDTH-1:0]    req_x,
    output logic [B_HEIGHT-1:0]   req_y,
    input  logic                  px_valid,
    input  logic [3*B_VGA-1:0]    px_rgb,
    output logic [3*B_VGA-1:0]    cell_rgb,
    output logic [B_WIDTH-1:0]    cell_x,
    output logic [B_HEIGHT-1:0]   cell_y,
    output logic                  cell_en,
    output logic                  update,
    output logic                  busy,
    output logic [7:0]            overrun_count
);

    localparam logic [B_WIDTH-1:0]  LAST_X = B_WIDTH'(WIDTH - 1);
    localparam logic [B_HEIGHT-1:0] LAST_Y = B_HEIGHT'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [B_WIDTH-1:0]    x_q, x_d;
    logic [B_HEIGHT-1:0]   y_q, y_d;
    logic [B_WIDTH-1:0]    cx_q, cx_d;
    logic [B_HEIGHT-1:0]   cy_q, cy_d;
    logic [3*B_VGA-1:0]    rgb_q, rgb_d;
    logic [7:0]            ovr_q, ovr_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end
        return v + 8'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        rgb_d   = rgb_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            S_IDLE: begin
                if (frame_start && enable) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (px_valid) begin
                    rgb_d   = px_rgb;
                    cx_d    = x_q;
                    cy_d    = y_q;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // The last cell leaves the counters parked so they never wrap.
                if (x_q == LAST_X) begin
                    if (y_q == LAST_Y) begin
                        state_d = S_DONE;
                    end else begin
                        x_d     = '0;
                        y_d     = y_q + 1'b1;
                        state_d = S_REQ;
                    end
                end else begin
                    x_d     = x_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any start request seen outside IDLE (including DONE) is an overrun.
        if (frame_start && (state_q != S_IDLE)) begin
            ovr_d = sat_inc8(ovr_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            rgb_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rgb_q   <= rgb_d;
            ovr_q   <= ovr_d;
        end
    end

    assign px_req        = (state_q == S_REQ);
    assign cell_en       = (state_q == S_WRITE);
    assign update        = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign req_x         = x_q;
    assign req_y         = y_q;
    assign cell_x        = cx_q;
    assign cell_y        = cy_q;
    assign cell_rgb      = rgb_q;
    assign overrun_count = ovr_q;

endmodule
